// File: rtl/accel_csr_ctrl_if.sv
// Register-port bundle for accel_csr_ctrl: single-cycle write port plus a
// read request whose data and hit flag are registered by the slave.
interface accel_csr_ctrl_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 20
);
    logic [31:0]               axi_wr_data;
    logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr;
    logic                      axi_wr_en;
    logic [3:0]                axi_wr_strobe;
    logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr;
    logic                      axi_rd_en;
    logic [31:0]               axi_rd_data;
    logic                      axi_rd_hit;

    modport master (
        output axi_wr_data, axi_wr_addr, axi_wr_en, axi_wr_strobe,
        output axi_rd_addr, axi_rd_en,
        input  axi_rd_data, axi_rd_hit
    );

    modport slave (
        input  axi_wr_data, axi_wr_addr, axi_wr_en, axi_wr_strobe,
        input  axi_rd_addr, axi_rd_en,
        output axi_rd_data, axi_rd_hit
    );
endinterface

// File: rtl/accel_csr_ctrl.sv
// accel_csr_ctrl: control/status registers and frame sequencer for a
// pixel accelerator. Tracks frames between first_pixel and frame_done,
// counts frames, raises a level interrupt and issues a timed soft reset.
// Optional feature macro CSR_CYCLE_COUNTER_EN adds the RUN_CYCLES and
// LAST_CYCLES counters; without it both registers read as 0 (still a hit).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame seen since reset / soft reset
// BUSY  | frame in flight (first_pixel seen, frame_done not yet)
// DONE  | last frame completed, waiting for the next first_pixel
module accel_csr_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH    = 20,
    parameter logic [31:0] CSR_BASE          = 32'h0006_0804,
    parameter int unsigned SOFT_RESET_CYCLES = 15,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    accel_csr_ctrl_if.slave   bus,
    input  logic              first_pixel,
    input  logic              frame_done,
    output logic              soft_rst_n,
    output logic              busy,
    output logic              irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] A_STATUS  = AXI_ADDR_WIDTH'(CSR_BASE + 32'h00);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_CONTROL = AXI_ADDR_WIDTH'(CSR_BASE + 32'h04);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_IRQ_CLR = AXI_ADDR_WIDTH'(CSR_BASE + 32'h08);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_FRAMES  = AXI_ADDR_WIDTH'(CSR_BASE + 32'h0C);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_LAST    = AXI_ADDR_WIDTH'(CSR_BASE + 32'h10);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_RUN     = AXI_ADDR_WIDTH'(CSR_BASE + 32'h14);
    localparam logic [7:0] SRST_LOAD = 8'(SOFT_RESET_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   irq_pending_q, irq_pending_d;
    logic                   irq_en_q, irq_en_d;
    logic                   srst_n_q, srst_n_d;
    logic [7:0]             srst_cnt_q, srst_cnt_d;
    logic                   busy_q, busy_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_hit_q, rd_hit_d;
`ifdef CSR_CYCLE_COUNTER_EN
    logic [CNT_WIDTH-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0]   last_cnt_q, last_cnt_d;
    logic [CNT_WIDTH-1:0]   run_cnt_sat;
`endif

    logic wr_lane0;
    logic wr_ctrl;
    logic wr_clr;
    logic srst_start;
    logic hold;
    logic frame_end;
    logic unused_wr_bits;

    // Only byte lane 0 carries control bits; the rest of the write word is don't-care.
    assign unused_wr_bits = ^{bus.axi_wr_data[31:2], bus.axi_wr_strobe[3:1]};

    assign wr_lane0   = bus.axi_wr_en && bus.axi_wr_strobe[0];
    assign wr_ctrl    = wr_lane0 && (bus.axi_wr_addr == A_CONTROL);
    assign wr_clr     = wr_lane0 && (bus.axi_wr_addr == A_IRQ_CLR) && bus.axi_wr_data[0];
    // A new soft reset only starts from the released state, so a request during the pulse cannot stretch it.
    assign srst_start = wr_ctrl && bus.axi_wr_data[0] && srst_n_q;
    // Datapath is frozen on the edge that starts the pulse and for every cycle the pulse is low.
    assign hold       = !srst_n_q || srst_start;

`ifdef CSR_CYCLE_COUNTER_EN
    assign run_cnt_sat = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_WIDTH'(1);
`endif

    // Next-state logic: frame FSM, counters, interrupt and soft-reset down-counter.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        irq_pending_d = irq_pending_q;
        irq_en_d      = irq_en_q;
        srst_n_d      = srst_n_q;
        srst_cnt_d    = srst_cnt_q;
        frame_end     = 1'b0;
`ifdef CSR_CYCLE_COUNTER_EN
        run_cnt_d     = run_cnt_q;
        last_cnt_d    = last_cnt_q;
`endif

        if (wr_ctrl) begin
            irq_en_d = bus.axi_wr_data[1];
        end

        if (srst_start) begin
            srst_n_d   = 1'b0;
            srst_cnt_d = SRST_LOAD;
        end else if (!srst_n_q) begin
            if (srst_cnt_q == 8'd0) begin
                srst_n_d = 1'b1;
            end else begin
                srst_cnt_d = srst_cnt_q - 8'd1;
            end
        end

        if (hold) begin
            state_d       = ST_IDLE;
            irq_pending_d = 1'b0;
`ifdef CSR_CYCLE_COUNTER_EN
            run_cnt_d     = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (first_pixel) begin
                        state_d = ST_BUSY;
`ifdef CSR_CYCLE_COUNTER_EN
                        run_cnt_d = '0;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef CSR_CYCLE_COUNTER_EN
                    run_cnt_d = run_cnt_sat;
`endif
                    // frame_done outranks a simultaneous first_pixel.
                    if (frame_done) begin
                        state_d     = ST_DONE;
                        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        frame_end   = 1'b1;
`ifdef CSR_CYCLE_COUNTER_EN
                        last_cnt_d  = run_cnt_sat;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A completing frame beats a clear issued in the same cycle.
            if (frame_end) begin
                irq_pending_d = 1'b1;
            end else if (wr_clr) begin
                irq_pending_d = 1'b0;
            end
        end

        busy_d = (state_d == ST_BUSY);
        irq_d  = irq_pending_d && irq_en_d;
    end

    // Register read mux; outputs hold while no read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_hit_d  = rd_hit_q;
        if (bus.axi_rd_en) begin
            rd_hit_d = 1'b1;
            case (bus.axi_rd_addr)
                A_STATUS:  rd_data_d = {29'd0, irq_pending_q, busy_q, (state_q == ST_DONE)};
                A_CONTROL: rd_data_d = {30'd0, irq_en_q, 1'b0};
                A_IRQ_CLR: rd_data_d = 32'd0;
                A_FRAMES:  rd_data_d = 32'(frame_cnt_q);
`ifdef CSR_CYCLE_COUNTER_EN
                A_LAST:    rd_data_d = 32'(last_cnt_q);
                A_RUN:     rd_data_d = 32'(run_cnt_q);
`else
                A_LAST:    rd_data_d = 32'd0;
                A_RUN:     rd_data_d = 32'd0;
`endif
                default: begin
                    rd_data_d = 32'd0;
                    rd_hit_d  = 1'b0;
                end
            endcase
        end
    end

    // State and register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            irq_pending_q <= 1'b0;
            irq_en_q      <= 1'b0;
            srst_n_q      <= 1'b1;
            srst_cnt_q    <= 8'd0;
            busy_q        <= 1'b0;
            irq_q         <= 1'b0;
            rd_data_q     <= 32'd0;
            rd_hit_q      <= 1'b0;
`ifdef CSR_CYCLE_COUNTER_EN
            run_cnt_q     <= '0;
            last_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            irq_pending_q <= irq_pending_d;
            irq_en_q      <= irq_en_d;
            srst_n_q      <= srst_n_d;
            srst_cnt_q    <= srst_cnt_d;
            busy_q        <= busy_d;
            irq_q         <= irq_d;
            rd_data_q     <= rd_data_d;
            rd_hit_q      <= rd_hit_d;
`ifdef CSR_CYCLE_COUNTER_EN
            run_cnt_q     <= run_cnt_d;
            last_cnt_q    <= last_cnt_d;
`endif
        end
    end

    assign soft_rst_n      = srst_n_q;
    assign busy            = busy_q;
    assign irq             = irq_q;
    assign bus.axi_rd_data = rd_data_q;
    assign bus.axi_rd_hit  = rd_hit_q;

endmodule

// File: tb/tb_accel_csr_ctrl.sv
// Directed bench for accel_csr_ctrl: one instance with default parameters,
// a second with CNT_WIDTH=8 for counter wrap and saturation.
module tb_accel_csr_ctrl;

`ifdef CSR_CYCLE_COUNTER_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    localparam logic [19:0] A_STATUS  = 20'h60804;
    localparam logic [19:0] A_CONTROL = 20'h60808;
    localparam logic [19:0] A_IRQ_CLR = 20'h6080C;
    localparam logic [19:0] A_FRAMES  = 20'h60810;
    localparam logic [19:0] A_LAST    = 20'h60814;
    localparam logic [19:0] A_RUN     = 20'h60818;
    localparam logic [19:0] A_MISS    = 20'h6081C;

    logic clk = 1'b0;
    logic rst_n;
    logic fp0, fd0, srst0, busy0, irq0;
    logic fp1, fd1, srst1, busy1, irq1;

    int errors = 0;
    int checks = 0;

    accel_csr_ctrl_if #(.AXI_ADDR_WIDTH(20)) bus0 ();
    accel_csr_ctrl_if #(.AXI_ADDR_WIDTH(20)) bus1 ();

    accel_csr_ctrl #(.AXI_ADDR_WIDTH(20), .CSR_BASE(32'h0006_0804),
                     .SOFT_RESET_CYCLES(15), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .first_pixel(fp0), .frame_done(fd0),
        .soft_rst_n(srst0), .busy(busy0), .irq(irq0)
    );

    accel_csr_ctrl #(.AXI_ADDR_WIDTH(20), .CSR_BASE(32'h0006_0804),
                     .SOFT_RESET_CYCLES(15), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .first_pixel(fp1), .frame_done(fd1),
        .soft_rst_n(srst1), .busy(busy1), .irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int which, input logic [19:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        if (which == 0) begin
            bus0.axi_wr_addr = a; bus0.axi_wr_data = d; bus0.axi_wr_strobe = s; bus0.axi_wr_en = 1'b1;
        end else begin
            bus1.axi_wr_addr = a; bus1.axi_wr_data = d; bus1.axi_wr_strobe = s; bus1.axi_wr_en = 1'b1;
        end
        tick();
        bus0.axi_wr_en = 1'b0;
        bus1.axi_wr_en = 1'b0;
    endtask

    task automatic rd(input int which, input logic [19:0] a, output logic [31:0] d, output logic h);
        if (which == 0) begin
            bus0.axi_rd_addr = a; bus0.axi_rd_en = 1'b1;
        end else begin
            bus1.axi_rd_addr = a; bus1.axi_rd_en = 1'b1;
        end
        tick();
        bus0.axi_rd_en = 1'b0;
        bus1.axi_rd_en = 1'b0;
        if (which == 0) begin
            d = bus0.axi_rd_data; h = bus0.axi_rd_hit;
        end else begin
            d = bus1.axi_rd_data; h = bus1.axi_rd_hit;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        int          busy_cnt;
        int          low_cnt;
        int          busy_seen;

        fp0 = 0; fd0 = 0; fp1 = 0; fd1 = 0;
        bus0.axi_wr_en = 0; bus0.axi_wr_addr = '0; bus0.axi_wr_data = '0; bus0.axi_wr_strobe = '0;
        bus0.axi_rd_en = 0; bus0.axi_rd_addr = '0;
        bus1.axi_wr_en = 0; bus1.axi_wr_addr = '0; bus1.axi_wr_data = '0; bus1.axi_wr_strobe = '0;
        bus1.axi_rd_en = 0; bus1.axi_rd_addr = '0;

        // Power-on reset
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_soft_rst_n", {31'd0, srst0}, 32'd1);
        chk("rst_busy",       {31'd0, busy0}, 32'd0);
        chk("rst_irq",        {31'd0, irq0},  32'd0);
        chk("rst_rd_data",    bus0.axi_rd_data, 32'd0);
        chk("rst_rd_hit",     {31'd0, bus0.axi_rd_hit}, 32'd0);
        #19 rst_n = 1'b1;
        tick();

        // Read decode: miss, hit, then hold with rd_en low
        rd(0, A_MISS, d, h);
        chk("miss_data", d, 32'd0);
        chk("miss_hit",  {31'd0, h}, 32'd0);
        rd(0, A_STATUS, d, h);
        chk("status_idle", d, 32'd0);
        chk("status_hit",  {31'd0, h}, 32'd1);
        bus0.axi_rd_addr = A_MISS;
        tick();
        chk("rd_hold_hit", {31'd0, bus0.axi_rd_hit}, 32'd1);

        // CONTROL irq_en and strobe gating
        wr(0, A_CONTROL, 32'h2, 4'hF);
        rd(0, A_CONTROL, d, h);
        chk("control_rw", d, 32'h2);
        wr(0, A_CONTROL, 32'h0, 4'b1110);
        rd(0, A_CONTROL, d, h);
        chk("control_strobe_gated", d, 32'h2);

        // 100-cycle frame
        fp0 = 1; tick(); fp0 = 0;
        busy_cnt = busy0 ? 1 : 0;
        repeat (99) begin
            tick();
            if (busy0) busy_cnt++;
        end
        fd0 = 1; tick(); fd0 = 0;
        chk("frame_busy_cycles", busy_cnt, 32'd100);
        chk("frame_busy_after",  {31'd0, busy0}, 32'd0);
        chk("frame_irq",         {31'd0, irq0}, 32'd1);
        rd(0, A_STATUS, d, h);
        chk("frame_status", d, 32'h5);
        rd(0, A_FRAMES, d, h);
        chk("frame_count_1", d, 32'd1);
        rd(0, A_LAST, d, h);
        chk("last_cycles_100", d, CYC ? 32'd100 : 32'd0);
        chk("last_cycles_hit", {31'd0, h}, 32'd1);
        rd(0, A_RUN, d, h);
        chk("run_cycles_hold_done", d, CYC ? 32'd100 : 32'd0);

        // IRQ clear
        wr(0, A_IRQ_CLR, 32'h1, 4'h1);
        chk("irq_clr", {31'd0, irq0}, 32'd0);
        rd(0, A_STATUS, d, h);
        chk("status_after_clr", d, 32'h1);

        // IRQ clear colliding with frame_done: set wins
        fp0 = 1; tick(); fp0 = 0;
        repeat (5) tick();
        fd0 = 1;
        wr(0, A_IRQ_CLR, 32'h1, 4'hF);
        fd0 = 0;
        chk("clr_vs_set_irq", {31'd0, irq0}, 32'd1);
        rd(0, A_FRAMES, d, h);
        chk("frame_count_2", d, 32'd2);
        rd(0, A_LAST, d, h);
        chk("last_cycles_6", d, CYC ? 32'd6 : 32'd0);
        wr(0, A_IRQ_CLR, 32'h1, 4'hF);

        // first_pixel and frame_done together in BUSY
        fp0 = 1; tick(); fp0 = 0;
        repeat (2) tick();
        fp0 = 1; fd0 = 1; tick(); fp0 = 0; fd0 = 0;
        chk("fp_fd_busy", {31'd0, busy0}, 32'd0);
        rd(0, A_STATUS, d, h);
        chk("fp_fd_status", d, 32'h5);
        rd(0, A_FRAMES, d, h);
        chk("frame_count_3", d, 32'd3);
        wr(0, A_IRQ_CLR, 32'h1, 4'hF);
        // frame_done while DONE is ignored
        fd0 = 1; tick(); fd0 = 0;
        rd(0, A_FRAMES, d, h);
        chk("fd_in_done_ignored", d, 32'd3);

        // Soft reset mid-frame; bit1 rewritten as 1 so irq_en retention is observable
        fp0 = 1; tick(); fp0 = 0;
        repeat (3) tick();
        chk("busy_before_srst", {31'd0, busy0}, 32'd1);
        wr(0, A_CONTROL, 32'h3, 4'hF);
        chk("srst_busy_clear", {31'd0, busy0}, 32'd0);
        low_cnt = (srst0 == 1'b0) ? 1 : 0;
        busy_seen = 0;
        bus0.axi_rd_addr = A_STATUS;
        bus0.axi_rd_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                wr(0, A_CONTROL, 32'h3, 4'hF);
            end else if (k == 8) begin
                fp0 = 1; tick(); fp0 = 0;
            end else begin
                tick();
            end
            if (busy0) busy_seen++;
            if (srst0 == 1'b0) low_cnt++;
            else break;
        end
        bus0.axi_rd_en = 1'b0;
        chk("srst_low_cycles", low_cnt, 32'd15);
        chk("srst_busy_during", busy_seen, 32'd0);
        chk("srst_status", bus0.axi_rd_data, 32'h0);
        tick();
        chk("srst_fp_ignored", {31'd0, busy0}, 32'd0);
        rd(0, A_FRAMES, d, h);
        chk("srst_frame_count_kept", d, 32'd3);
        rd(0, A_CONTROL, d, h);
        chk("srst_irq_en_kept", d, 32'h2);

        // frame_done alone in IDLE
        fd0 = 1; tick(); fd0 = 0;
        chk("fd_idle_busy", {31'd0, busy0}, 32'd0);
        rd(0, A_STATUS, d, h);
        chk("fd_idle_status", d, 32'h0);
        rd(0, A_FRAMES, d, h);
        chk("fd_idle_frames", d, 32'd3);

        // Async reset mid-frame: frame must not resume
        fp0 = 1; tick(); fp0 = 0;
        chk("busy_before_rst", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_busy", {31'd0, busy0}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_no_resume", {31'd0, busy0}, 32'd0);
        rd(0, A_STATUS, d, h);
        chk("rst_status", d, 32'h0);
        rd(0, A_FRAMES, d, h);
        chk("rst_frames", d, 32'd0);
        rd(0, A_CONTROL, d, h);
        chk("rst_control", d, 32'h0);

        // CNT_WIDTH=8 instance: frame counter wrap
        repeat (255) begin
            fp1 = 1; tick(); fp1 = 0;
            fd1 = 1; tick(); fd1 = 0;
        end
        rd(1, A_FRAMES, d, h);
        chk("w8_frames_255", d, 32'h0000_00FF);
        fp1 = 1; tick(); fp1 = 0;
        fd1 = 1; tick(); fd1 = 0;
        rd(1, A_FRAMES, d, h);
        chk("w8_frames_wrap", d, 32'd0);

        // CNT_WIDTH=8 instance: 300-cycle frame saturates cycle counters
        fp1 = 1; tick(); fp1 = 0;
        repeat (299) tick();
        fd1 = 1; tick(); fd1 = 0;
        rd(1, A_LAST, d, h);
        chk("w8_last_sat", d, CYC ? 32'd255 : 32'd0);
        rd(1, A_RUN, d, h);
        chk("w8_run_sat", d, CYC ? 32'd255 : 32'd0);
        rd(1, A_FRAMES, d, h);
        chk("w8_frames_1", d, 32'd1);
        rd(1, A_STATUS, d, h);
        chk("w8_status", d, 32'h5);
        chk("w8_irq_masked", {31'd0, irq1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
